// File: rtl/dispense_sequencer_if.sv
// Command/status bundle between the dispense controller and the dispense sequencer.
// The controller drives start/recipe_id/abort; the sequencer drives motor and status outputs.
interface dispense_sequencer_if;
    logic       start;
    logic [3:0] recipe_id;
    logic       abort;
    logic [2:0] motor_en;
    logic       motor_dir;
    logic [1:0] channel;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start,
        output recipe_id,
        output abort,
        input  motor_en,
        input  motor_dir,
        input  channel,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  recipe_id,
        input  abort,
        output motor_en,
        output motor_dir,
        output channel,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/dispense_sequencer.sv
// Recipe-driven lower/hold/raise sequencer for the red, yellow and blue dispense channels.
// All outputs are registered; phase lengths are counted in prescaled motion ticks.
module dispense_sequencer #(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned DEPTH_UNIT = 5,
    parameter int unsigned STAY_UNIT  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    dispense_sequencer_if.slave  bus
);

    if (3 * DEPTH_UNIT > 255 || 3 * STAY_UNIT > 255 || TICK_DIV < 2) begin : g_bad_param
        $error("dispense_sequencer: TICK_DIV, DEPTH_UNIT or STAY_UNIT out of range");
    end

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StDown, StHold, StUp, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    phase_q, phase_d;
    logic [1:0]    chan_q, chan_d;
    logic [5:0]    lvl_q, lvl_d;
    logic [2:0]    en_q, en_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          running;
    logic          tick;
    logic          phase_end;
    logic [5:0]    new_lvl;
    logic [1:0]    cur_lvl;
    logic [1:0]    next_lvl;

    // Levels packed as {blue, yellow, red}, two bits each.
    function automatic logic [5:0] level_lookup(input logic [3:0] id);
        logic [5:0] lv;
        case (id)
            4'd0:    lv = {2'd1, 2'd1, 2'd1};
            4'd1:    lv = {2'd1, 2'd1, 2'd2};
            4'd2:    lv = {2'd1, 2'd2, 2'd1};
            4'd3:    lv = {2'd2, 2'd1, 2'd1};
            4'd4:    lv = {2'd1, 2'd2, 2'd2};
            4'd5:    lv = {2'd2, 2'd2, 2'd1};
            4'd6:    lv = {2'd2, 2'd1, 2'd2};
            4'd7:    lv = {2'd1, 2'd2, 2'd3};
            4'd8:    lv = {2'd2, 2'd1, 2'd3};
            4'd9:    lv = {2'd1, 2'd3, 2'd2};
            4'd10:   lv = {2'd2, 2'd3, 2'd1};
            4'd11:   lv = {2'd3, 2'd1, 2'd2};
            default: lv = 6'd0;
        endcase
        return lv;
    endfunction

    function automatic logic [1:0] chan_level(input logic [5:0] lv, input logic [1:0] ch);
        logic [1:0] l;
        case (ch)
            2'd1:    l = lv[3:2];
            2'd2:    l = lv[5:4];
            default: l = lv[1:0];
        endcase
        return l;
    endfunction

    function automatic logic [7:0] scale(input logic [1:0] lvl, input int unsigned unit);
        return 8'(lvl) * 8'(unit);
    endfunction

    assign running   = (state_q == StDown) || (state_q == StHold) || (state_q == StUp);
    assign tick      = running && (presc_q == PRESC_MAX);
    assign phase_end = tick && (phase_q == 8'd1);
    assign new_lvl   = level_lookup(bus.recipe_id);
    assign cur_lvl   = chan_level(lvl_q, chan_q);
    assign next_lvl  = chan_level(lvl_q, chan_q + 2'd1);

    always_comb begin
        state_d = state_q;
        presc_d = running ? (tick ? '0 : presc_q + PW'(1)) : '0;
        phase_d = tick ? phase_q - 8'd1 : phase_q;
        chan_d  = chan_q;
        lvl_d   = lvl_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    if (bus.recipe_id <= 4'd11) begin
                        lvl_d   = new_lvl;
                        chan_d  = 2'd0;
                        presc_d = '0;
                        phase_d = scale(new_lvl[1:0], DEPTH_UNIT);
                        state_d = StDown;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDown: begin
                if (phase_end) begin
                    phase_d = scale(cur_lvl, STAY_UNIT);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (phase_end) begin
                    phase_d = scale(cur_lvl, DEPTH_UNIT);
                    state_d = StUp;
                end
            end
            StUp: begin
                if (phase_end) begin
                    if (chan_q == 2'd2) begin
                        chan_d  = 2'd0;
                        phase_d = 8'd0;
                        state_d = StDone;
                    end else begin
                        // Next channel starts lowering on the same edge, no idle gap.
                        chan_d  = chan_q + 2'd1;
                        phase_d = scale(next_lvl, DEPTH_UNIT);
                        state_d = StDown;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus.abort && running) begin
            state_d = StIdle;
            chan_d  = 2'd0;
            presc_d = '0;
            phase_d = 8'd0;
        end

        // Outputs are a registered function of the next state.
        en_d   = ((state_d == StDown) || (state_d == StUp)) ? (3'b001 << chan_d) : 3'b000;
        dir_d  = (state_d == StDown) || (state_d == StHold);
        busy_d = (state_d == StDown) || (state_d == StHold) || (state_d == StUp);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            presc_q <= '0;
            phase_q <= 8'd0;
            chan_q  <= 2'd0;
            lvl_q   <= 6'd0;
            en_q    <= 3'b000;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            chan_q  <= chan_d;
            lvl_q   <= lvl_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.motor_en  = en_q;
    assign bus.motor_dir = dir_q;
    assign bus.channel   = chan_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Scoreboard bench for dispense_sequencer: stimulus pushes expected output segments
// (vector + duration) derived from the recipe table; a monitor run-length encodes the outputs.
module tb_dispense_sequencer;

    localparam int TD = 4;
    localparam int DU = 5;
    localparam int SU = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dispense_sequencer_if bus ();

    dispense_sequencer #(
        .TICK_DIV   (TD),
        .DEPTH_UNIT (DU),
        .STAY_UNIT  (SU)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] en;
        logic       dir;
        logic [1:0] ch;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    typedef struct {
        vec_t v;
        int   len;
    } seg_t;

    seg_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Recipe levels (red, yellow, blue).
    int lvl_tab [12][3] = '{'{1,1,1}, '{2,1,1}, '{1,2,1}, '{1,1,2},
                            '{2,2,1}, '{1,2,2}, '{2,1,2}, '{3,2,1},
                            '{3,1,2}, '{2,3,1}, '{1,3,2}, '{2,1,3}};

    // ph: 0 lower, 1 hold, 2 raise
    function automatic int phase_len(int id, int ch, int ph);
        int l = lvl_tab[id][ch];
        return (ph == 1 ? l * SU : l * DU) * TD;
    endfunction

    function automatic int phase_start(int id, int ch, int ph);
        int s = 0;
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 3; p++)
                if (c * 3 + p < ch * 3 + ph) s += phase_len(id, c, p);
        return s;
    endfunction

    function automatic int total(int id);
        return phase_start(id, 2, 2) + phase_len(id, 2, 2);
    endfunction

    // cut < 0: full run ending with a done pulse; otherwise only the first cut cycles.
    task automatic push_run(int id, int cut);
        int   remaining = cut;
        seg_t s;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (cut >= 0 && remaining == 0) return;
                s.v      = '0;
                s.v.en   = (p != 1) ? 3'(1 << c) : 3'b000;
                s.v.dir  = (p != 2);
                s.v.ch   = 2'(c);
                s.v.busy = 1'b1;
                s.len    = phase_len(id, c, p);
                if (cut >= 0) begin
                    if (s.len > remaining) s.len = remaining;
                    remaining -= s.len;
                end
                exp_q.push_back(s);
            end
        end
        if (cut < 0) begin
            s.v      = '0;
            s.v.done = 1'b1;
            s.len    = 1;
            exp_q.push_back(s);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(int id);
        bus.start     = 1'b1;
        bus.recipe_id = 4'(id);
        cyc(1);
        bus.start     = 1'b0;
    endtask

    // Called in the first cycle after the accept edge; returns in an idle cycle.
    task automatic play(int id, bit noise, int nid);
        int t = total(id);
        for (int c = 0; c < t; c++) begin
            bus.start     = noise && ($urandom_range(0, 3) == 0);
            bus.recipe_id = (nid >= 0) ? 4'(nid) : 4'($urandom_range(0, 15));
            cyc(1);
        end
        // Start on the done cycle must be ignored.
        bus.start     = 1'b1;
        bus.recipe_id = 4'd0;
        cyc(1);
        bus.start = 1'b0;
        cyc($urandom_range(1, 3));
    endtask

    task automatic run_full(int id, bit noise, int nid);
        push_run(id, -1);
        accept(id);
        play(id, noise, nid);
    endtask

    task automatic run_abort(int id, int k);
        push_run(id, k + 1);
        accept(id);
        cyc(k);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        cyc($urandom_range(1, 3));
    endtask

    task automatic reject(int id, bit with_abort);
        seg_t s;
        if (!with_abort) begin
            s.v     = '0;
            s.v.err = 1'b1;
            s.len   = 1;
            exp_q.push_back(s);
        end
        bus.start     = 1'b1;
        bus.recipe_id = 4'(id);
        bus.abort     = with_abort;
        cyc(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc(2);
    endtask

    task automatic run_rst(int id, int k, int id2);
        push_run(id, k + 1);
        accept(id);
        cyc(k);
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.recipe_id = 4'(id2);
        cyc(1);
        push_run(id2, -1);
        rst = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        play(id2, 1'b0, 0);
    endtask

    // Monitor
    vec_t cur_v;
    vec_t run_v   = '0;
    int   run_len = 0;
    bit   mon_on  = 1'b0;
    bit   chk_zero = 1'b0;
    bit   end_req  = 1'b0;
    seg_t e;

    always @(negedge clk) begin
        cur_v = {bus.motor_en, bus.motor_dir, bus.channel, bus.busy, bus.done, bus.err};
        if (chk_zero) begin
            checks++;
            if (cur_v != '0) begin
                failures++;
                $display("FAIL reset_outputs got=%b expected=%b", cur_v, 9'b0);
            end
        end
        if (mon_on) begin
            if (cur_v != run_v) begin
                if (run_v != '0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_segment got vec=%b len=%0d expected none",
                                 run_v, run_len);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.v != run_v || e.len != run_len) begin
                            failures++;
                            $display("FAIL segment got vec=%b len=%0d expected vec=%b len=%0d",
                                     run_v, run_len, e.v, e.len);
                        end
                    end
                end
                run_v   = cur_v;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
        if (end_req) begin
            end_req = 1'b0;
            checks++;
            if (exp_q.size() != 0 || run_v != '0) begin
                failures++;
                $display("FAIL pending_segments got=%0d expected=0", exp_q.size());
            end
        end
    end

    initial begin
        int id;
        bus.start     = 1'b0;
        bus.recipe_id = 4'd0;
        bus.abort     = 1'b0;
        rst           = 1'b1;
        cyc(3);
        chk_zero = 1'b1;
        @(negedge clk);
        #1 chk_zero = 1'b0;
        cyc(1);
        rst    = 1'b0;
        mon_on = 1'b1;
        cyc(2);

        bus.abort = 1'b1;               // abort while idle has no effect
        cyc(1);
        bus.abort = 1'b0;

        run_full(0, 1'b0, 0);
        run_full(7, 1'b0, 0);
        reject(12, 1'b0);
        reject(15, 1'b0);
        reject(13, 1'b1);               // abort beats start: no err
        run_full(1, 1'b1, 3);
        run_abort(5, phase_start(5, 1, 1) + 5);
        run_full(2, 1'b0, 0);
        run_rst(6, phase_start(6, 2, 2) + 3, 9);

        for (int i = 0; i < 6; i++) begin
            id = $urandom_range(0, 11);
            if ($urandom_range(0, 1) == 0) run_full(id, 1'b1, -1);
            else run_abort(id, $urandom_range(0, total(id) - 1));
            if ($urandom_range(0, 2) == 0) reject($urandom_range(12, 15), 1'b0);
        end

        cyc(3);
        end_req = 1'b1;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
